grid_ctrl: RTL and testbench

Owner of the cell-state vector that feeds the grid renderer's `data` input. Accepts single-cell write requests from game logic through a valid/ready port and buffers them in a small FIFO. Applies buffered writes and whole-grid clear sweeps only while `vblank` is high, so the displayed frame never tears. Sits between the game FSM and the grid renderer in the same clock domain as the pixel counters.

---
 rtl/grid_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_grid_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/grid_ctrl.sv
// rtl/grid_ctrl.sv - cell-state grid owner: buffered single-cell writes and clear sweeps applied only during vblank.
// Optional clear sweep is built when GRID_CTRL_CLEAR_EN is defined.
module grid_ctrl #(
    parameter int SIZE_X     = 10,
    parameter int SIZE_Y     = 10,
    parameter int CELL_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int XBITS      = $clog2(SIZE_X),
    parameter int YBITS      = $clog2(SIZE_Y),
    parameter int GDBITS     = CELL_BITS * SIZE_X * SIZE_Y
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [XBITS-1:0]     wr_x,
    input  logic [YBITS-1:0]     wr_y,
    input  logic [CELL_BITS-1:0] wr_type,
    input  logic                 clr_req,
    input  logic [CELL_BITS-1:0] clr_type,
    input  logic                 vblank,
    output logic [GDBITS-1:0]    data,
    output logic                 busy,
    output logic                 wr_err
);

    localparam int NCELLS = SIZE_X * SIZE_Y;
    localparam int IW     = $clog2(NCELLS + 1);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int EW     = XBITS + YBITS + CELL_BITS;

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [EW-1:0]       fifo_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [GDBITS-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                wr_err_q, wr_err_d;

    logic                full, push, pop, oor;
    logic [EW-1:0]       head;
    logic [XBITS-1:0]    head_x;
    logic [YBITS-1:0]    head_y;
    logic [CELL_BITS-1:0] head_t;
    logic                cell_we;
    logic [IW-1:0]       cell_idx;
    logic [CELL_BITS-1:0] cell_val;

`ifdef GRID_CTRL_CLEAR_EN
    logic                 clr_pend_q, clr_pend_d;
    logic [CELL_BITS-1:0] clr_type_q, clr_type_d;
    logic [CELL_BITS-1:0] sweep_type_q, sweep_type_d;
    logic [IW-1:0]        sweep_q, sweep_d;
    logic                 start_clr;
`else
    logic unused_clr;
    assign unused_clr = ^{clr_req, clr_type};
`endif

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign data     = data_q;
    assign busy     = busy_q;
    assign wr_err   = wr_err_q;

    assign head   = fifo_q[rd_ptr_q];
    assign head_x = head[EW-1 -: XBITS];
    assign head_y = head[CELL_BITS +: YBITS];
    assign head_t = head[CELL_BITS-1:0];
    // Widen by one bit so a grid dimension equal to 2**BITS still compares correctly.
    assign oor    = ({1'b0, head_x} >= (XBITS+1)'(SIZE_X)) ||
                    ({1'b0, head_y} >= (YBITS+1)'(SIZE_Y));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef GRID_CTRL_CLEAR_EN
        case (state_q)
            ST_IDLE:  if (vblank && clr_pend_q) state_d = ST_CLEAR;
            ST_CLEAR: if (vblank && sweep_q == IW'(NCELLS - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
`else
        state_d = ST_IDLE;
`endif
    end

    always_comb begin
        pop      = (state_q == ST_IDLE) && vblank && (count_q != '0);
        cell_we  = 1'b0;
        cell_idx = '0;
        cell_val = '0;
`ifdef GRID_CTRL_CLEAR_EN
        pop          = pop && !clr_pend_q;
        start_clr    = (state_q == ST_IDLE) && (state_d == ST_CLEAR);
        clr_pend_d   = clr_req ? 1'b1 : (start_clr ? 1'b0 : clr_pend_q);
        clr_type_d   = clr_req ? clr_type : clr_type_q;
        sweep_type_d = start_clr ? clr_type_q : sweep_type_q;
        sweep_d      = sweep_q;
        if (start_clr) begin
            sweep_d = '0;
        end else if (state_q == ST_CLEAR && vblank) begin
            sweep_d  = sweep_q + IW'(1);
            cell_we  = 1'b1;
            cell_idx = sweep_q;
            cell_val = sweep_type_q;
        end
`endif
        if (pop && !oor) begin
            cell_we  = 1'b1;
            cell_idx = IW'(head_y) * IW'(SIZE_X) + IW'(head_x);
            cell_val = head_t;
        end

        data_d = data_q;
        for (int i = 0; i < NCELLS; i++) begin
            if (cell_we && cell_idx == IW'(i)) data_d[i*CELL_BITS +: CELL_BITS] = cell_val;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_err_d = pop && oor;
`ifdef GRID_CTRL_CLEAR_EN
        busy_d   = (count_d != '0) || clr_pend_d || (state_d == ST_CLEAR);
`else
        busy_d   = (count_d != '0);
`endif
    end

    // Storage array needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {wr_x, wr_y, wr_type};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            wr_err_q <= wr_err_d;
        end
    end

`ifdef GRID_CTRL_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_pend_q   <= 1'b0;
            clr_type_q   <= '0;
            sweep_type_q <= '0;
            sweep_q      <= '0;
        end else begin
            clr_pend_q   <= clr_pend_d;
            clr_type_q   <= clr_type_d;
            sweep_type_q <= sweep_type_d;
            sweep_q      <= sweep_d;
        end
    end
`endif

endmodule

// File: tb/tb_grid_ctrl.sv
// tb/tb_grid_ctrl.sv - directed self-checking bench for grid_ctrl.
module tb_grid_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_x;
    logic [3:0]  wr_y;
    logic [0:0]  wr_type;
    logic        clr_req;
    logic [0:0]  clr_type;
    logic        vblank;
    logic [99:0] data;
    logic        busy;
    logic        wr_err;

    logic [99:0] exp_data;
    int          n_checks = 0;
    int          n_err    = 0;

    grid_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_type  (wr_type),
        .clr_req  (clr_req),
        .clr_type (clr_type),
        .vblank   (vblank),
        .data     (data),
        .busy     (busy),
        .wr_err   (wr_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chkd(input string tag, input logic [99:0] obs, input logic [99:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_one(input int x, input int y, input int t);
        wr_valid = 1'b1;
        wr_x     = 4'(x);
        wr_y     = 4'(y);
        wr_type  = 1'(t);
        step(1);
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_type = '0;
        clr_req = 1'b0; clr_type = '0; vblank = 1'b0; exp_data = '0;

        #12;
        chkd("rst_data", data, '0);
        chk1("rst_ready", wr_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", wr_err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single write (3,2,1) -> bit 23
        vblank = 1'b1;
        push_one(3, 2, 1);
        chk1("w1_busy_after_push", busy, 1'b1);
        chkd("w1_data_before_pop", data, exp_data);
        step(1);
        exp_data[23] = 1'b1;
        chkd("w1_data", data, exp_data);
        chk1("w1_busy_done", busy, 1'b0);

        // fill FIFO with vblank low, fifth write stalls until space frees
        vblank = 1'b0;
        push_one(0, 0, 1);
        push_one(9, 9, 1);
        push_one(5, 1, 1);
        push_one(1, 5, 1);
        wr_valid = 1'b1; wr_x = 4'd3; wr_y = 4'd2; wr_type = 1'b0;
        chk1("full_ready", wr_ready, 1'b0);
        step(1);
        chk1("full_ready_hold", wr_ready, 1'b0);
        chkd("full_no_apply", data, exp_data);
        chk1("full_busy", busy, 1'b1);
        vblank = 1'b1;
        step(1);
        exp_data[0] = 1'b1;
        chkd("drain_a", data, exp_data);
        chk1("drain_a_ready", wr_ready, 1'b1);
        step(1);
        wr_valid = 1'b0;
        exp_data[99] = 1'b1;
        chkd("drain_b", data, exp_data);
        step(1);
        exp_data[15] = 1'b1;
        chkd("drain_c", data, exp_data);
        step(1);
        exp_data[51] = 1'b1;
        chkd("drain_d", data, exp_data);
        chk1("drain_d_busy", busy, 1'b1);
        step(1);
        exp_data[23] = 1'b0;
        chkd("drain_e_fifth", data, exp_data);
        chk1("drain_e_busy", busy, 1'b0);

        // out of range x, then out of range y followed by in-range edge cell (9,0)
        push_one(10, 0, 1);
        chk1("oorx_err_pre", wr_err, 1'b0);
        step(1);
        chk1("oorx_err_pulse", wr_err, 1'b1);
        chkd("oorx_data", data, exp_data);
        step(1);
        chk1("oorx_err_end", wr_err, 1'b0);
        push_one(0, 10, 1);
        push_one(9, 0, 1);
        chk1("oory_err_pulse", wr_err, 1'b1);
        chkd("oory_data", data, exp_data);
        step(1);
        exp_data[9] = 1'b1;
        chk1("edge_err_clear", wr_err, 1'b0);
        chkd("edge_x9_data", data, exp_data);

        // vblank gating
        vblank = 1'b0;
        push_one(2, 7, 1);
        step(3);
        chkd("gate_hold", data, exp_data);
        chk1("gate_busy", busy, 1'b1);
        vblank = 1'b1;
        step(1);
        exp_data[72] = 1'b1;
        chkd("gate_release", data, exp_data);
        chk1("gate_busy_done", busy, 1'b0);

`ifdef GRID_CTRL_CLEAR_EN
        // two queued type-0 writes, clear type 1 (latest request wins), pause mid-sweep
        vblank = 1'b0;
        push_one(3, 2, 0);
        push_one(0, 0, 0);
        clr_req = 1'b1; clr_type = 1'b0;
        step(1);
        clr_type = 1'b1;
        step(1);
        clr_req = 1'b0; clr_type = 1'b0;
        chk1("clr_busy", busy, 1'b1);
        vblank = 1'b1;
        step(1);
        chkd("clr_start", data, exp_data);
        step(40);
        exp_data[39:0] = '1;
        chkd("clr_40", data, exp_data);
        vblank = 1'b0;
        step(50);
        chkd("clr_paused", data, exp_data);
        vblank = 1'b1;
        step(59);
        exp_data[98:40] = '1;
        chkd("clr_99", data, exp_data);
        chk1("clr_busy_mid", busy, 1'b1);
        step(1);
        exp_data = '1;
        chkd("clr_done", data, exp_data);
        step(1);
        exp_data[23] = 1'b0;
        chkd("clr_q1", data, exp_data);
        step(1);
        exp_data[0] = 1'b0;
        chkd("clr_q2", data, exp_data);
        chk1("clr_busy_end", busy, 1'b0);
`else
        // clear request has no effect without the clear feature
        clr_req = 1'b1; clr_type = 1'b1;
        step(1);
        clr_req = 1'b0;
        chk1("noclr_busy", busy, 1'b0);
        step(3);
        chkd("noclr_data", data, exp_data);
`endif

        // asynchronous reset with queued work
        vblank = 1'b0;
        push_one(4, 4, 1);
        push_one(6, 6, 1);
`ifdef GRID_CTRL_CLEAR_EN
        clr_req = 1'b1; clr_type = 1'b0;
        step(1);
        clr_req = 1'b0;
        vblank = 1'b1;
        step(10);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chkd("arst_data", data, '0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_ready", wr_ready, 1'b1);
        chk1("arst_err", wr_err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        vblank = 1'b1;
        step(3);
        chkd("arst_fifo_empty", data, '0);
        chk1("arst_busy_after", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
